// File: rtl/biquad_pkg.sv
// Shared constants, FSM encoding and helpers for the multi-channel biquad cascade.
package biquad_pkg;

   localparam logic [2:0] TAP_B0 = 3'd0;
   localparam logic [2:0] TAP_B1 = 3'd1;
   localparam logic [2:0] TAP_B2 = 3'd2;
   localparam logic [2:0] TAP_A1 = 3'd3;
   localparam logic [2:0] TAP_A2 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_WB   = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   // Five products of WIDTH_D x WIDTH_C need three guard bits.
   function automatic int unsigned acc_width(input int unsigned wd, input int unsigned wc);
      return wd + wc + 3;
   endfunction

   // Unity gain in a coefficient with frac fractional bits.
   function automatic logic signed [63:0] passthrough_coef(input int unsigned frac);
      return 64'sd1 <<< frac;
   endfunction

endpackage

// File: rtl/biquad_multi_if.sv
// Sample, coefficient and result signals of biquad_multi grouped as one bus.
interface biquad_multi_if #(
   parameter int unsigned WIDTH_D  = 18,
   parameter int unsigned WIDTH_C  = 18,
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned NUM_SECT = 2
);
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned ADDR_W = (5 * NUM_SECT > 1) ? $clog2(5 * NUM_SECT) : 1;

   logic                      inStrobe;
   logic [CH_W-1:0]           inChannel;
   logic signed [WIDTH_D-1:0] dataIn;
   logic                      inReady;
   logic                      coefWe;
   logic [ADDR_W-1:0]         coefAddr;
   logic signed [WIDTH_C-1:0] coefData;
   logic                      outStrobe;
   logic [CH_W-1:0]           outChannel;
   logic signed [WIDTH_D-1:0] dataOut;
   logic                      overflow;

   modport master (
      output inStrobe, inChannel, dataIn, coefWe, coefAddr, coefData,
      input  inReady, outStrobe, outChannel, dataOut, overflow
   );

   modport slave (
      input  inStrobe, inChannel, dataIn, coefWe, coefAddr, coefData,
      output inReady, outStrobe, outChannel, dataOut, overflow
   );
endinterface

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate with arithmetic rescale; BIQUAD_MULTI_SAT_EN selects
// saturating instead of wrapping reduction to WIDTH_D.
module biquad_mac
   import biquad_pkg::*;
#(
   parameter int unsigned WIDTH_D    = 18,
   parameter int unsigned WIDTH_C    = 18,
   parameter int unsigned COEFF_FRAC = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic                      clr_i,
   input  logic                      sub_i,
   input  logic signed [WIDTH_C-1:0] coef_i,
   input  logic signed [WIDTH_D-1:0] data_i,
   output logic signed [WIDTH_D-1:0] result_c_o
);
   localparam int unsigned ACC_W  = acc_width(WIDTH_D, WIDTH_C);
   localparam int unsigned PROD_W = WIDTH_D + WIDTH_C;

   logic signed [ACC_W-1:0]  acc_q, acc_d, base_c;
   logic signed [PROD_W-1:0] prod_c;

   always_comb begin
      prod_c = PROD_W'(coef_i) * PROD_W'(data_i);
      base_c = clr_i ? '0 : acc_q;
      acc_d  = sub_i ? base_c - ACC_W'(prod_c) : base_c + ACC_W'(prod_c);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_d;
      end
   end

`ifdef BIQUAD_MULTI_SAT_EN
   logic signed [ACC_W-1:0] shifted_c;
   logic                    in_range_c;

   // In range when every bit above the result sign bit matches it.
   always_comb begin
      shifted_c  = acc_q >>> COEFF_FRAC;
      in_range_c = (&shifted_c[ACC_W-1:WIDTH_D-1]) || !(|shifted_c[ACC_W-1:WIDTH_D-1]);
      if (in_range_c) begin
         result_c_o = {shifted_c[WIDTH_D-1], shifted_c[WIDTH_D-2:0]};
      end else if (shifted_c[ACC_W-1]) begin
         result_c_o = {1'b1, {(WIDTH_D-1){1'b0}}};
      end else begin
         result_c_o = {1'b0, {(WIDTH_D-1){1'b1}}};
      end
   end
`else
   assign result_c_o = WIDTH_D'(acc_q >>> COEFF_FRAC);
`endif

endmodule

// File: rtl/biquad_multi.sv
// Time-multiplexed DF-I biquad cascade over NUM_CH channels with loadable coefficients.
// Optional result saturation via BIQUAD_MULTI_SAT_EN (in biquad_mac).
module biquad_multi
   import biquad_pkg::*;
#(
   parameter int unsigned WIDTH_D    = 18,
   parameter int unsigned WIDTH_C    = 18,
   parameter int unsigned COEFF_FRAC = 16,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned NUM_SECT   = 2
) (
   input logic           clk,
   input logic           rst,
   biquad_multi_if.slave bus
);
   localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned NUM_COEF = 5 * NUM_SECT;
   localparam int unsigned ADDR_W   = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
   localparam int unsigned SECT_W   = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
   localparam int unsigned HS_W     = $clog2(NUM_SECT + 1);
   localparam logic signed [WIDTH_C-1:0] COEF_PASS = WIDTH_C'(passthrough_coef(COEFF_FRAC));

   state_e                    state_q, state_d;
   logic [SECT_W-1:0]         sect_q, sect_d;
   logic [2:0]                tap_q, tap_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic signed [WIDTH_D-1:0] xin_q, xin_d;
   logic                      in_ready_q, in_ready_d;
   logic                      out_strobe_q, out_strobe_d;
   logic [CH_W-1:0]           out_ch_q;
   logic signed [WIDTH_D-1:0] data_out_q;
   logic                      overflow_q;

   logic signed [WIDTH_C-1:0] coef_q [NUM_COEF];
   // hist_q[c][s] is the x-history of section s; hist_q[c][s+1] is its y-history.
   logic signed [WIDTH_D-1:0] hist_q [NUM_CH][NUM_SECT+1][2];

   logic                      accept_c, coef_ok_c, ovf_set_c;
   logic                      mac_en_c, mac_clr_c, mac_sub_c, hist_we_c, last_sect_c;
   logic [ADDR_W-1:0]         coef_idx_c;
   logic [HS_W-1:0]           hidx_c, hnext_c;
   logic signed [WIDTH_C-1:0] coef_c;
   logic signed [WIDTH_D-1:0] operand_c, mac_result_c;

   always_comb begin
      accept_c    = bus.inStrobe && in_ready_q && (32'(bus.inChannel) < NUM_CH);
      coef_ok_c   = bus.coefWe && in_ready_q && (32'(bus.coefAddr) < NUM_COEF);
      ovf_set_c   = (bus.inStrobe && !accept_c) || (bus.coefWe && !coef_ok_c);
      coef_idx_c  = ADDR_W'(32'(sect_q) * 32'd5 + 32'(tap_q));
      coef_c      = coef_q[coef_idx_c];
      hidx_c      = HS_W'(sect_q);
      hnext_c     = hidx_c + HS_W'(1);
      last_sect_c = (32'(sect_q) == NUM_SECT - 1);
      mac_clr_c   = (tap_q == TAP_B0);
      mac_sub_c   = (tap_q == TAP_A1) || (tap_q == TAP_A2);
      case (tap_q)
         TAP_B0:  operand_c = xin_q;
         TAP_B1:  operand_c = hist_q[ch_q][hidx_c][0];
         TAP_B2:  operand_c = hist_q[ch_q][hidx_c][1];
         TAP_A1:  operand_c = hist_q[ch_q][hnext_c][0];
         default: operand_c = hist_q[ch_q][hnext_c][1];
      endcase
   end

   biquad_mac #(
      .WIDTH_D    (WIDTH_D),
      .WIDTH_C    (WIDTH_C),
      .COEFF_FRAC (COEFF_FRAC)
   ) u_mac (
      .clk        (clk),
      .rst        (rst),
      .en_i       (mac_en_c),
      .clr_i      (mac_clr_c),
      .sub_i      (mac_sub_c),
      .coef_i     (coef_c),
      .data_i     (operand_c),
      .result_c_o (mac_result_c)
   );

   // Next-state and control decode.
   always_comb begin
      state_d      = state_q;
      sect_d       = sect_q;
      tap_d        = tap_q;
      ch_d         = ch_q;
      xin_d        = xin_q;
      out_strobe_d = 1'b0;
      mac_en_c     = 1'b0;
      hist_we_c    = 1'b0;
      case (state_q)
         ST_IDLE, ST_OUT: begin
            state_d = ST_IDLE;
            if (accept_c) begin
               state_d = ST_MAC;
               sect_d  = '0;
               tap_d   = TAP_B0;
               ch_d    = bus.inChannel;
               xin_d   = bus.dataIn;
            end
         end
         ST_MAC: begin
            mac_en_c = 1'b1;
            if (tap_q == TAP_A2) begin
               state_d = ST_WB;
            end else begin
               tap_d = tap_q + 3'd1;
            end
         end
         ST_WB: begin
            hist_we_c = 1'b1;
            xin_d     = mac_result_c;
            tap_d     = TAP_B0;
            if (last_sect_c) begin
               state_d      = ST_OUT;
               out_strobe_d = 1'b1;
            end else begin
               state_d = ST_MAC;
               sect_d  = sect_q + SECT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE) || (state_d == ST_OUT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         sect_q       <= '0;
         tap_q        <= TAP_B0;
         ch_q         <= '0;
         xin_q        <= '0;
         in_ready_q   <= 1'b1;
         out_strobe_q <= 1'b0;
         out_ch_q     <= '0;
         data_out_q   <= '0;
         overflow_q   <= 1'b0;
         hist_q       <= '{default: '0};
         for (int unsigned i = 0; i < NUM_COEF; i++) begin
            coef_q[i] <= (i % 5 == 0) ? COEF_PASS : '0;
         end
      end else begin
         state_q      <= state_d;
         sect_q       <= sect_d;
         tap_q        <= tap_d;
         ch_q         <= ch_d;
         xin_q        <= xin_d;
         in_ready_q   <= in_ready_d;
         out_strobe_q <= out_strobe_d;
         if (out_strobe_d) begin
            out_ch_q   <= ch_q;
            data_out_q <= mac_result_c;
         end
         if (ovf_set_c) overflow_q <= 1'b1;
         if (coef_ok_c) coef_q[bus.coefAddr] <= bus.coefData;
         // The upstream y-history doubles as this section's x-history, so it only
         // shifts once this section has consumed it; the last section shifts its own.
         if (hist_we_c) begin
            hist_q[ch_q][hidx_c][0] <= xin_q;
            hist_q[ch_q][hidx_c][1] <= hist_q[ch_q][hidx_c][0];
            if (last_sect_c) begin
               hist_q[ch_q][hnext_c][0] <= mac_result_c;
               hist_q[ch_q][hnext_c][1] <= hist_q[ch_q][hnext_c][0];
            end
         end
      end
   end

   assign bus.inReady    = in_ready_q;
   assign bus.outStrobe  = out_strobe_q;
   assign bus.outChannel = out_ch_q;
   assign bus.dataOut    = data_out_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_biquad_multi.sv
// Directed self-checking bench for biquad_multi at default parameters.
module tb_biquad_multi;
   localparam int unsigned WIDTH_D    = 18;
   localparam int unsigned WIDTH_C    = 18;
   localparam int unsigned COEFF_FRAC = 16;
   localparam int unsigned NUM_CH     = 2;
   localparam int unsigned NUM_SECT   = 2;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   biquad_multi_if #(
      .WIDTH_D(WIDTH_D), .WIDTH_C(WIDTH_C), .NUM_CH(NUM_CH), .NUM_SECT(NUM_SECT)
   ) bus ();

   biquad_multi #(
      .WIDTH_D(WIDTH_D), .WIDTH_C(WIDTH_C), .COEFF_FRAC(COEFF_FRAC),
      .NUM_CH(NUM_CH), .NUM_SECT(NUM_SECT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp_val);
      checks++;
      assert (obs === exp_val) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic write_coef(input int addr, input int data);
      bus.coefWe   = 1'b1;
      bus.coefAddr = 4'(addr);
      bus.coefData = WIDTH_C'(data);
      @(negedge clk);
      bus.coefWe   = 1'b0;
   endtask

   // Feed one sample and wait (bounded) for its result.
   task automatic expect_sample(input string tag, input logic ch, input int d, input int exp_val);
      int lat;
      lat           = 0;
      bus.inStrobe  = 1'b1;
      bus.inChannel = ch;
      bus.dataIn    = WIDTH_D'(d);
      do begin
         @(negedge clk);
         bus.inStrobe = 1'b0;
         lat++;
      end while (!bus.outStrobe && lat < 40);
      check({tag, "_lat"}, lat, 13);
      check({tag, "_ch"}, 32'(bus.outChannel), 32'(ch));
      check({tag, "_data"}, $signed(bus.dataOut), exp_val);
   endtask

   initial begin
      int   lat;
      logic ready_mid;
      logic saw;
      bus.inStrobe  = 1'b0;
      bus.inChannel = '0;
      bus.dataIn    = '0;
      bus.coefWe    = 1'b0;
      bus.coefAddr  = '0;
      bus.coefData  = '0;

      // Reset state and passthrough
      do_reset();
      check("rst_outStrobe", 32'(bus.outStrobe), 0);
      check("rst_outChannel", 32'(bus.outChannel), 0);
      check("rst_dataOut", $signed(bus.dataOut), 0);
      check("rst_overflow", 32'(bus.overflow), 0);
      check("rst_inReady", 32'(bus.inReady), 1);
      expect_sample("pass", 1'b0, 1000, 1000);
      @(negedge clk);
      check("pass_strobe_one_cycle", 32'(bus.outStrobe), 0);
      check("pass_hold", $signed(bus.dataOut), 1000);
      check("pass_no_ovf", 32'(bus.overflow), 0);
      write_coef(10, 0);
      check("addr_range_ovf", 32'(bus.overflow), 1);

      // Channel isolation, back-to-back samples accepted in the OUT cycle
      do_reset();
      write_coef(0, 16384);
      write_coef(1, 16384);
      write_coef(2, 16384);
      expect_sample("iso_c1_0", 1'b1, 4000, 1000);
      expect_sample("iso_c0_0", 1'b0, 500, 125);
      expect_sample("iso_c1_1", 1'b1, 0, 1000);
      expect_sample("iso_c0_1", 1'b0, 500, 250);
      expect_sample("iso_c1_2", 1'b1, 0, 1000);
      expect_sample("iso_c0_2", 1'b0, 500, 375);
      expect_sample("iso_c1_3", 1'b1, 0, 0);
      expect_sample("iso_c0_3", 1'b0, 500, 375);

      // Feedback: y = x + 0.5*y1
      do_reset();
      write_coef(3, -32768);
      expect_sample("fb_0", 1'b0, 8192, 8192);
      expect_sample("fb_1", 1'b0, 0, 4096);
      expect_sample("fb_2", 1'b0, 0, 2048);
      expect_sample("fb_3", 1'b0, 0, 1024);

      // Saturate or wrap: 131071*131071>>16 = 262140
      do_reset();
      write_coef(0, 131071);
      write_coef(5, 131071);
`ifdef BIQUAD_MULTI_SAT_EN
      expect_sample("sat", 1'b0, 131071, 131071);
`else
      expect_sample("wrap", 1'b0, 131071, -8);
`endif

      // Busy violations: strobe and coefficient write while computing
      do_reset();
      lat           = 0;
      ready_mid     = 1'b1;
      bus.inStrobe  = 1'b1;
      bus.inChannel = 1'b0;
      bus.dataIn    = 18'sd1000;
      bus.coefAddr  = '0;
      bus.coefData  = '0;
      do begin
         @(negedge clk);
         lat++;
         bus.inStrobe  = (lat == 3);
         bus.inChannel = 1'b1;
         bus.dataIn    = 18'sd9999;
         bus.coefWe    = (lat == 4);
         if (lat == 2) ready_mid = bus.inReady;
      end while (!bus.outStrobe && lat < 40);
      bus.inStrobe = 1'b0;
      bus.coefWe   = 1'b0;
      check("busy_ready", 32'(ready_mid), 0);
      check("busy_lat", lat, 13);
      check("busy_ch", 32'(bus.outChannel), 0);
      check("busy_data", $signed(bus.dataOut), 1000);
      check("busy_ovf", 32'(bus.overflow), 1);
      expect_sample("busy_coef_kept", 1'b0, 1000, 1000);

      // Reset mid-operation abandons the sample and restores coefficients
      do_reset();
      write_coef(1, 65536);
      expect_sample("pre_rst", 1'b0, 300, 300);
      saw           = 1'b0;
      bus.inStrobe  = 1'b1;
      bus.inChannel = 1'b0;
      bus.dataIn    = 18'sd5000;
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk);
         bus.inStrobe = 1'b0;
         if (n == 5) rst = 1'b0;
         if (n == 6) rst = 1'b1;
         if (bus.outStrobe) saw = 1'b1;
      end
      check("midrst_no_strobe", 32'(saw), 0);
      check("midrst_ready", 32'(bus.inReady), 1);
      check("midrst_ovf", 32'(bus.overflow), 0);
      expect_sample("post_rst", 1'b0, 700, 700);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
